// File: rtl/knn_selector.sv
// knn_selector: K-nearest-neighbour selection and majority vote.
//
// Consumes one (distance, data_type) result per training sample, keeps the
// K smallest distances in a sorted list, then counts the stored types
// (VCOUNT) and picks the most frequent class (VMAX). The winning class is
// presented on result_type together with a one-cycle result_valid pulse.
//
// Optional feature macro: KNN_TIE_NEAREST_EN
//   defined   - equal vote counts are broken by the class whose nearest entry
//               sits at the smaller list index
//   undefined - equal vote counts go to the lowest class index
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   start        clear the list and begin a new classification (also aborts)
//   dist_valid   sample qualifier
//   distance     unsigned distance of the current sample
//   data_type    class of the current sample
//   last         marks the final sample (qualified by dist_valid)
//   busy         high whenever the FSM is not idle
//   result_type  classified type, all ones when no entry voted
//   result_valid one-cycle pulse while the new result_type is presented
module knn_selector #(
  parameter int K = 3,
  parameter int T = 4,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dist_valid,
  input  logic [W-1:0] distance,
  input  logic [W-1:0] data_type,
  input  logic         last,
  output logic         busy,
  output logic [W-1:0] result_type,
  output logic         result_valid
);
  localparam int CW = $clog2(K + 1);
  localparam int MX = (K > T) ? K : T;
  localparam int IW = $clog2(MX + 1);
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int TW = (T > 1) ? $clog2(T) : 1;

  typedef enum logic [2:0] {IDLE, ACCUM, VCOUNT, VMAX, DONE} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [K-1:0]  vld_q, vld_d;
  logic [W-1:0]  dist_q [K];
  logic [W-1:0]  dist_d [K];
  logic [W-1:0]  type_q [K];
  logic [W-1:0]  type_d [K];

  logic [CW-1:0] cnt_q [T];
  logic [CW-1:0] best_cnt_q, best_cnt_n;
  logic [W-1:0]  best_cls_q, best_cls_n;
  logic [W-1:0]  result_q;
  logic          rd_vld_p0;
  logic [TW-1:0] rd_cls_p0;
`ifdef KNN_TIE_NEAREST_EN
  logic [KW-1:0] near_q [T];
  logic [KW-1:0] best_near_q, best_near_n;
  logic [KW-1:0] rd_idx_p0;
`endif

  logic          accept;
  logic          better;
  logic [K-1:0]  base_vld, hit;
  logic [KW-1:0] ent;
  logic [TW-1:0] cls;

  assign ent          = idx_q[KW-1:0];
  assign cls          = idx_q[TW-1:0];
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result_type  = result_q;

  // Single-cycle sorted insertion. hit[] is monotonic because valid entries
  // are ascending and invalid ones trail, so the first hit is the insertion
  // point and every later hit takes its upper neighbour. Strict compare keeps
  // an earlier equal-distance sample ahead of a later one.
  always_comb begin
    accept   = dist_valid && ((state_q == ACCUM) || start);
    base_vld = start ? '0 : vld_q;
    for (int i = 0; i < K; i++) begin
      hit[i] = !base_vld[i] || (distance < dist_q[i]);
    end
    vld_d  = base_vld;
    dist_d = dist_q;
    type_d = type_q;
    if (accept) begin
      if (hit[0]) begin
        vld_d[0]  = 1'b1;
        dist_d[0] = distance;
        type_d[0] = data_type;
      end
      for (int i = 1; i < K; i++) begin
        if (hit[i] && !hit[i-1]) begin
          vld_d[i]  = 1'b1;
          dist_d[i] = distance;
          type_d[i] = data_type;
        end else if (hit[i]) begin
          vld_d[i]  = base_vld[i-1];
          dist_d[i] = dist_q[i-1];
          type_d[i] = type_q[i-1];
        end
      end
    end
  end

  // Arg-max step for the class addressed by idx_q.
  always_comb begin
    better = (cnt_q[cls] > best_cnt_q);
`ifdef KNN_TIE_NEAREST_EN
    if ((cnt_q[cls] == best_cnt_q) && (cnt_q[cls] != '0) && (near_q[cls] < best_near_q)) begin
      better = 1'b1;
    end
    best_near_n = best_near_q;
`endif
    best_cnt_n = best_cnt_q;
    best_cls_n = best_cls_q;
    if (better) begin
      best_cnt_n = cnt_q[cls];
      best_cls_n = W'(cls);
`ifdef KNN_TIE_NEAREST_EN
      best_near_n = near_q[cls];
`endif
    end
  end

  // VCOUNT spends K cycles reading entries plus one to retire the last read,
  // which is where the K+T+1 edge latency comes from.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:   ;
      ACCUM: begin
        if (accept && last) begin
          state_d = VCOUNT;
          idx_d   = '0;
        end
      end
      VCOUNT: begin
        if (idx_q == IW'(K)) begin
          state_d = VMAX;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      VMAX: begin
        if (idx_q == IW'(T - 1)) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = (accept && last) ? VCOUNT : ACCUM;
      idx_d   = '0;
    end
  end

  // ---- p0: list storage and entry read for the vote counter ----
  always_ff @(posedge clk) begin
    dist_q    <= dist_d;
    type_q    <= type_d;
    rd_cls_p0 <= type_q[ent][TW-1:0];
`ifdef KNN_TIE_NEAREST_EN
    rd_idx_p0 <= ent;
`endif
  end

  // ---- control, vote counters and arg-max ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      vld_q      <= '0;
      rd_vld_p0  <= 1'b0;
      best_cnt_q <= '0;
      best_cls_q <= '1;
      result_q   <= '0;
      for (int c = 0; c < T; c++) cnt_q[c] <= '0;
`ifdef KNN_TIE_NEAREST_EN
      best_near_q <= '0;
      for (int c = 0; c < T; c++) near_q[c] <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      vld_q     <= vld_d;
      // Out-of-range types stay in the list but never reach a counter.
      rd_vld_p0 <= (state_q == VCOUNT) && (idx_q < IW'(K)) && vld_q[ent] &&
                   (type_q[ent] < W'(T)) && !start;
      if (start) begin
        best_cnt_q <= '0;
        best_cls_q <= '1;
        for (int c = 0; c < T; c++) cnt_q[c] <= '0;
      end else begin
        if (rd_vld_p0) begin
          cnt_q[rd_cls_p0] <= cnt_q[rd_cls_p0] + 1'b1;
`ifdef KNN_TIE_NEAREST_EN
          // Entries are read in list order, so the first vote is the nearest.
          if (cnt_q[rd_cls_p0] == '0) near_q[rd_cls_p0] <= rd_idx_p0;
`endif
        end
        if (state_q == VMAX) begin
          best_cnt_q <= best_cnt_n;
          best_cls_q <= best_cls_n;
`ifdef KNN_TIE_NEAREST_EN
          best_near_q <= best_near_n;
`endif
          // Loaded on the edge into DONE so the pulse sees the new value;
          // the all-ones seed survives when no class got a vote.
          if (idx_q == IW'(T - 1)) result_q <= best_cls_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_knn_selector.sv
module tb_knn_selector;
  localparam int K = 3;
  localparam int T = 4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         dist_valid = 1'b0;
  logic         last = 1'b0;
  logic [W-1:0] distance = '0;
  logic [W-1:0] data_type = '0;
  logic         busy;
  logic         result_valid;
  logic [W-1:0] result_type;

  int checks = 0;
  int errors = 0;

  knn_selector #(.K(K), .T(T), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dist_valid   (dist_valid),
    .distance     (distance),
    .data_type    (data_type),
    .last         (last),
    .busy         (busy),
    .result_type  (result_type),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic st, input logic dv, input logic [W-1:0] d,
                       input logic [W-1:0] t, input logic l);
    @(negedge clk);
    start      = st;
    dist_valid = dv;
    distance   = d;
    data_type  = t;
    last       = l;
  endtask

  task automatic quiet();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Counts negedges after the one following the accepting edge; bounded.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result_type !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b valid=%b type=%h required 0 0 0", busy, result_valid, result_type);
    end
    checks++;
    if (dut.vld_q !== 3'b000) begin
      errors++;
      $display("FAIL reset_list vld=%b required 000", dut.vld_q);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_ignore();
    logic seen;
    seen = 1'b0;
    drive(1'b0, 1'b1, 32'd4, 32'd1, 1'b1);
    quiet();
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (busy !== 1'b0 || result_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore activity=%b required 0", seen);
    end
  endtask

  task automatic test_basic_vote();
    logic [W-1:0] ed [3];
    logic [W-1:0] et [3];
    int lat;
    ed = '{32'd10, 32'd20, 32'd30};
    et = '{32'd2, 32'd1, 32'd2};
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'd50, 32'd1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_rise busy=%b required 1", busy);
    end
    drive(1'b0, 1'b1, 32'd10, 32'd2, 1'b0);
    drive(1'b0, 1'b1, 32'd30, 32'd2, 1'b0);
    drive(1'b0, 1'b1, 32'd20, 32'd1, 1'b0);
    drive(1'b0, 1'b1, 32'd40, 32'd3, 1'b1);
    quiet();
    for (int i = 0; i < K; i++) begin
      checks++;
      if (dut.vld_q[i] !== 1'b1 || dut.dist_q[i] !== ed[i] || dut.type_q[i] !== et[i]) begin
        errors++;
        $display("FAIL basic_list[%0d] v=%b d=%0d t=%0d required 1 %0d %0d",
                 i, dut.vld_q[i], dut.dist_q[i], dut.type_q[i], ed[i], et[i]);
      end
    end
    wait_valid(lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL basic_latency got=%0d required 8", lat);
    end
    checks++;
    if (result_type !== 32'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_result type=%0d busy=%b required 2 1", result_type, busy);
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse_end valid=%b busy=%b required 0 0", result_valid, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (result_type !== 32'd2) begin
      errors++;
      $display("FAIL basic_hold type=%0d required 2", result_type);
    end
  endtask

  task automatic test_fewer_than_k();
    int lat;
    drive(1'b1, 1'b1, 32'd7, 32'd3, 1'b1);
    quiet();
    checks++;
    if (dut.vld_q !== 3'b001 || dut.dist_q[0] !== 32'd7 || dut.type_q[0] !== 32'd3) begin
      errors++;
      $display("FAIL fewer_list vld=%b d0=%0d t0=%0d required 001 7 3", dut.vld_q, dut.dist_q[0], dut.type_q[0]);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 8 || result_type !== 32'd3) begin
      errors++;
      $display("FAIL fewer_result lat=%0d type=%0d required 8 3", lat, result_type);
    end
  endtask

  task automatic test_three_way_tie();
    int lat;
    logic [W-1:0] exp_t;
`ifdef KNN_TIE_NEAREST_EN
    exp_t = 32'd3;
`else
    exp_t = 32'd0;
`endif
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'd5, 32'd3, 1'b0);
    drive(1'b0, 1'b1, 32'd6, 32'd1, 1'b0);
    drive(1'b0, 1'b1, 32'd9, 32'd0, 1'b1);
    quiet();
    wait_valid(lat);
    checks++;
    if (lat !== 8 || result_type !== exp_t) begin
      errors++;
      $display("FAIL tie_result lat=%0d type=%0d required 8 %0d", lat, result_type, exp_t);
    end
  endtask

  task automatic test_equal_distances();
    int lat;
    logic [W-1:0] et [3];
    et = '{32'd1, 32'd2, 32'd3};
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'd10, 32'd1, 1'b0);
    drive(1'b0, 1'b1, 32'd10, 32'd2, 1'b0);
    drive(1'b0, 1'b1, 32'd10, 32'd3, 1'b0);
    drive(1'b0, 1'b1, 32'd10, 32'd0, 1'b1);
    quiet();
    for (int i = 0; i < K; i++) begin
      checks++;
      if (dut.vld_q[i] !== 1'b1 || dut.dist_q[i] !== 32'd10 || dut.type_q[i] !== et[i]) begin
        errors++;
        $display("FAIL equal_list[%0d] v=%b d=%0d t=%0d required 1 10 %0d",
                 i, dut.vld_q[i], dut.dist_q[i], dut.type_q[i], et[i]);
      end
    end
    wait_valid(lat);
    checks++;
    if (lat !== 8 || result_type !== 32'd1) begin
      errors++;
      $display("FAIL equal_result lat=%0d type=%0d required 8 1", lat, result_type);
    end
  endtask

  task automatic test_out_of_range();
    int lat;
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'd1, 32'd7, 1'b0);
    drive(1'b0, 1'b1, 32'd2, 32'd9, 1'b1);
    quiet();
    wait_valid(lat);
    checks++;
    if (lat !== 8 || result_type !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL oor_result lat=%0d type=%h required 8 ffffffff", lat, result_type);
    end
  endtask

  task automatic test_abort_and_reset();
    int lat;
    logic seen;
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'd1, 32'd1, 1'b0);
    drive(1'b0, 1'b1, 32'd2, 32'd1, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'd3, 32'd2, 1'b1);
    quiet();
    checks++;
    if (dut.vld_q !== 3'b001) begin
      errors++;
      $display("FAIL abort_list vld=%b required 001", dut.vld_q);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 8 || result_type !== 32'd2) begin
      errors++;
      $display("FAIL abort_result lat=%0d type=%0d required 8 2", lat, result_type);
    end
    // New run, reset asserted while VMAX is scanning.
    drive(1'b1, 1'b1, 32'd5, 32'd1, 1'b1);
    quiet();
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_busy busy=%b required 1", busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || result_type !== '0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun busy=%b type=%h valid=%b required 0 0 0", busy, result_type, result_valid);
    end
    seen = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (result_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_pulse activity=%b required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic_vote();
    test_fewer_than_k();
    test_three_way_tie();
    test_equal_distances();
    test_out_of_range();
    test_abort_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/knn_selector.md
# knn_selector

Downstream stage of the distance calculator in the KNN classifier. It consumes the stream of (distance, data_type) results, one per training sample, and keeps the K smallest distances in a sorted on-chip list. After the last sample it runs a majority vote over the stored types and presents the classified type with a single-cycle valid pulse.

## Interface
- K, 3: number of nearest neighbours kept (≥1)
- T, 4: number of classes; legal types are 0..T-1
- W, 32: distance and type width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-low
- start  in  1  clears the list and begins a new classification
- dist_valid  in  1  sample qualifier (driven by calculator `done`)
- distance  in  W  unsigned distance of the current sample
- data_type  in  W  type of the current sample
- last  in  1  qualified by dist_valid; marks the final sample
- busy  out  1  high whenever the state is not IDLE
- result_type  out  W  classified type; held until the next start
- result_valid  out  1  one-cycle pulse when result_type updates

## Operation
- **States:** IDLE, ACCUM, VCOUNT, VMAX, DONE.
- **IDLE:**
  - start → ACCUM.
  - dist_valid is ignored.
- **Accept condition:** dist_valid && (state==ACCUM || start).
- **Start and sample in the same cycle:** the list is cleared and the sample becomes entry 0.
- **start in any non-IDLE state:** aborts the current run, clears the list and goes to ACCUM. result_type keeps its old value.
- **List:**
  - K entries of {valid, dist[W], type[W]}, sorted ascending.
  - Insertion is a single cycle:
    - Entry i is replaced if the new distance is strictly below entry i, or entry i is invalid.
    - Entries below the insertion point shift down.
    - Entry K-1 drops out.
  - A sample whose distance is ≥ all K valid entries is discarded.
  - Equal distances: the earlier sample ranks nearer.
- **last accepted → VCOUNT.**
  - Runs K cycles, one entry per cycle.
  - A per-class counter increments when the entry is valid and its type < T.
  - Out-of-range types are stored but do not vote.
  - Counters are ceil(log2(K+1)) bits wide.
- **VMAX:**
  - Runs T cycles, scanning classes 0..T-1.
  - A class replaces the current best only if its count is strictly greater.
  - Ties therefore go to the lowest class index, unless KNN_TIE_NEAREST_EN is defined.
- **DONE:**
  - result_type is loaded and result_valid = 1 for this one cycle.
  - Next state is IDLE.
  - If every count is 0, result_type = {W{1'b1}}.
- dist_valid is ignored in VCOUNT, VMAX and DONE.

## Timing
- **Reset values:** state IDLE, all entries invalid, all counters 0, busy 0, result_type 0, result_valid 0.
- **Throughput:** one sample per cycle in ACCUM; there is no backpressure.
- **Latency:** result_valid is high in the cycle that begins K+T+1 rising edges after the edge that accepted the last sample. With K=3 and T=4 this is 8 edges.
- **busy:**
  - Rises on the edge that takes start.
  - Falls on the edge leaving DONE.
- Reset asserted mid-run takes effect immediately: outputs return to reset values and no result_valid pulse is produced.

## Configuration
- **KNN_TIE_NEAREST_EN defined:** VMAX also records, for each class, the list index of its nearest valid entry. On equal counts, the class whose nearest entry has the smaller index wins.
- **KNN_TIE_NEAREST_EN undefined:** on equal counts, the lowest class index wins.

## Test plan
All scenarios use K=3, T=4, W=32.
1. **Basic vote.**
   - Stimulus: start, then (50,t1), (10,t2), (30,t2), (20,t1), (40,t3,last) on consecutive cycles.
   - Required: list holds 10/20/30 with types 2/1/2; result_type = 2; result_valid pulses exactly 8 edges after last.
2. **Fewer samples than K.**
   - Stimulus: start+dist_valid with (7,t3,last) in the same cycle.
   - Required: result_type = 3; entries 1..2 stay invalid.
3. **Three-way tie.**
   - Stimulus: (5,t3), (6,t1), (9,t0,last).
   - Required: result_type = 0 with KNN_TIE_NEAREST_EN undefined; result_type = 3 with it defined.
4. **Equal distances.**
   - Stimulus: (10,t1), (10,t2), (10,t3), (10,t0,last).
   - Required: kept types are 1/2/3 in that order; result_type = 1 in both configurations.
5. **Out-of-range types.**
   - Stimulus: (1,t7), (2,t9,last).
   - Required: result_type = 0xFFFFFFFF with a result_valid pulse.
6. **Abort and reset.**
   - Stimulus: start mid-ACCUM, then (3,t2,last).
   - Required: result_type = 2, with no influence from earlier samples.
   - Stimulus: assert rst during VMAX.
   - Required: no result_valid pulse; busy = 0 and result_type = 0 immediately.
